// File: rtl/variable_node_update.sv
// Variable-node belief update: multiplies unary beliefs by NUM_MSG factor messages
// in Q0.8, max-normalizes by left shifts and hands the belief pair downstream.
module variable_node_update #(
  parameter int unsigned NUM_MSG = 3
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] unary0,
  input  logic [7:0] unary1,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg0,
  input  logic [7:0] msg1,
  output logic       belief_valid,
  input  logic       belief_ready,
  output logic [7:0] belief0,
  output logic [7:0] belief1,
  output logic [2:0] norm_shift,
  output logic       busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_NORM,
    S_OUT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_acc0;
  logic [DW-1:0] r_acc1;
  logic [DW-1:0] w_acc0_nxt;
  logic [DW-1:0] w_acc1_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] r_shift;
  logic [SW-1:0] w_shift_nxt;
  logic          r_msg_ready;
  logic          r_belief_valid;
  logic          r_busy;
  logic [DW-1:0] w_mul0;
  logic [DW-1:0] w_mul1;

  // Q0.8 product keeps the upper byte, truncated
  assign w_mul0 = DW'((PW'(r_acc0) * PW'(msg0)) >> DW);
  assign w_mul1 = DW'((PW'(r_acc1) * PW'(msg1)) >> DW);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_acc0_nxt  = r_acc0;
    w_acc1_nxt  = r_acc1;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc0_nxt  = unary0;
          w_acc1_nxt  = unary1;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (msg_valid) begin
          w_acc0_nxt = w_mul0;
          w_acc1_nxt = w_mul1;
          w_cnt_nxt  = r_cnt + CW'(1);
          if (r_cnt == CW'(NUM_MSG - 1)) begin
            w_state_nxt = S_NORM;
          end
        end
      end
      S_NORM: begin
        if ((r_acc0 == '0) && (r_acc1 == '0)) begin
          w_state_nxt = S_OUT;
        end else if (!r_acc0[DW-1] && !r_acc1[DW-1]) begin
          w_acc0_nxt  = {r_acc0[DW-2:0], 1'b0};
          w_acc1_nxt  = {r_acc1[DW-2:0], 1'b0};
          w_shift_nxt = r_shift + SW'(1);
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (belief_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge CLK100MHZ or negedge Reset) begin
    if (!Reset) begin
      r_state        <= S_IDLE;
      r_acc0         <= '0;
      r_acc1         <= '0;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_msg_ready    <= 1'b0;
      r_belief_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_acc0         <= w_acc0_nxt;
      r_acc1         <= w_acc1_nxt;
      r_cnt          <= w_cnt_nxt;
      r_shift        <= w_shift_nxt;
      r_msg_ready    <= (w_state_nxt == S_ACCUM);
      r_belief_valid <= (w_state_nxt == S_OUT);
      r_busy         <= (w_state_nxt != S_IDLE);
    end
  end

  assign msg_ready    = r_msg_ready;
  assign belief_valid = r_belief_valid;
  assign busy         = r_busy;
  assign belief0      = r_acc0;
  assign belief1      = r_acc1;
  assign norm_shift   = r_shift;

endmodule

// File: tb/tb_variable_node_update.sv
// Directed bench for variable_node_update with hand-computed Q0.8 results.
module tb_variable_node_update;

  logic       CLK100MHZ = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] unary0 = '0;
  logic [7:0] unary1 = '0;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic [7:0] msg0 = '0;
  logic [7:0] msg1 = '0;
  logic       belief_valid;
  logic       belief_ready = 1'b1;
  logic [7:0] belief0;
  logic [7:0] belief1;
  logic [2:0] norm_shift;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  variable_node_update #(.NUM_MSG(3)) dut (
    .CLK100MHZ    (CLK100MHZ),
    .Reset        (Reset),
    .start        (start),
    .unary0       (unary0),
    .unary1       (unary1),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg0         (msg0),
    .msg1         (msg1),
    .belief_valid (belief_valid),
    .belief_ready (belief_ready),
    .belief0      (belief0),
    .belief1      (belief1),
    .norm_shift   (norm_shift),
    .busy         (busy)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] u0, input logic [7:0] u1);
    start  = 1'b1;
    unary0 = u0;
    unary1 = u1;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] m0, input logic [7:0] m1);
    msg_valid = 1'b1;
    msg0      = m0;
    msg1      = m1;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    msg_valid = 1'b0;
  endtask

  // Count negedges until belief_valid, bounded at 20
  task automatic wait_valid(output int n);
    n = 0;
    while (!belief_valid && n < 20) begin
      @(negedge CLK100MHZ);
      n++;
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_msg_ready", int'(msg_ready), 0);
    chk("rst_belief_valid", int'(belief_valid), 0);
    chk("rst_belief0", int'(belief0), 0);
    chk("rst_belief1", int'(belief1), 0);
    chk("rst_norm_shift", int'(norm_shift), 0);
    @(negedge CLK100MHZ);
    Reset = 1'b1;

    // Nominal case
    do_start(8'd128, 8'd64);
    chk("nom_busy", int'(busy), 1);
    chk("nom_msg_ready", int'(msg_ready), 1);
    chk("nom_load0", int'(belief0), 128);
    send(8'd255, 8'd255);
    chk("nom_acc0_m1", int'(belief0), 127);
    chk("nom_acc1_m1", int'(belief1), 63);
    send(8'd128, 8'd128);
    chk("nom_acc0_m2", int'(belief0), 63);
    chk("nom_acc1_m2", int'(belief1), 31);
    send(8'd200, 8'd100);
    chk("nom_acc0_m3", int'(belief0), 49);
    chk("nom_acc1_m3", int'(belief1), 12);
    chk("nom_ready_drop", int'(msg_ready), 0);
    wait_valid(cyc);
    chk("nom_latency", cyc, 3);
    chk("nom_belief0", int'(belief0), 196);
    chk("nom_belief1", int'(belief1), 48);
    chk("nom_shift", int'(norm_shift), 2);
    @(negedge CLK100MHZ);
    chk("nom_idle_busy", int'(busy), 0);
    chk("nom_idle_valid", int'(belief_valid), 0);

    // All-zero input
    do_start(8'd0, 8'd0);
    send(8'd17, 8'd99);
    send(8'd255, 8'd1);
    send(8'd3, 8'd200);
    wait_valid(cyc);
    chk("zero_latency", cyc, 1);
    chk("zero_belief0", int'(belief0), 0);
    chk("zero_belief1", int'(belief1), 0);
    chk("zero_shift", int'(norm_shift), 0);
    @(negedge CLK100MHZ);

    // Near-unity chain
    do_start(8'd255, 8'd255);
    send(8'd255, 8'd255);
    send(8'd255, 8'd255);
    send(8'd255, 8'd255);
    wait_valid(cyc);
    chk("unity_latency", cyc, 1);
    chk("unity_belief0", int'(belief0), 252);
    chk("unity_belief1", int'(belief1), 252);
    chk("unity_shift", int'(norm_shift), 0);
    @(negedge CLK100MHZ);

    // Flow control with gaps, stall and ignored starts
    belief_ready = 1'b0;
    do_start(8'd128, 8'd64);
    send(8'd255, 8'd255);
    start  = 1'b1;
    unary0 = 8'd1;
    unary1 = 8'd1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    chk("fc_gap1_acc0", int'(belief0), 127);
    chk("fc_gap1_ready", int'(msg_ready), 1);
    @(negedge CLK100MHZ);
    chk("fc_gap2_acc1", int'(belief1), 63);
    send(8'd128, 8'd128);
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
    chk("fc_gap3_acc0", int'(belief0), 63);
    chk("fc_gap3_busy", int'(busy), 1);
    send(8'd200, 8'd100);
    wait_valid(cyc);
    chk("fc_latency", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK100MHZ);
      chk("fc_stall_valid", int'(belief_valid), 1);
      chk("fc_stall_b0", int'(belief0), 196);
      chk("fc_stall_b1", int'(belief1), 48);
      chk("fc_stall_shift", int'(norm_shift), 2);
    end
    belief_ready = 1'b1;
    start        = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    chk("fc_idle_busy", int'(busy), 0);
    chk("fc_idle_valid", int'(belief_valid), 0);
    chk("fc_idle_ready", int'(msg_ready), 0);
    @(negedge CLK100MHZ);
    chk("fc_no_restart", int'(busy), 0);

    // Reset mid-update
    do_start(8'd128, 8'd64);
    send(8'd255, 8'd255);
    #2;
    Reset = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_msg_ready", int'(msg_ready), 0);
    chk("mrst_valid", int'(belief_valid), 0);
    chk("mrst_belief0", int'(belief0), 0);
    @(negedge CLK100MHZ);
    Reset = 1'b1;
    do_start(8'd128, 8'd64);
    send(8'd255, 8'd255);
    send(8'd128, 8'd128);
    send(8'd200, 8'd100);
    wait_valid(cyc);
    chk("mrst_latency", cyc, 3);
    chk("mrst_belief0_out", int'(belief0), 196);
    chk("mrst_belief1_out", int'(belief1), 48);
    chk("mrst_shift", int'(norm_shift), 2);
    @(negedge CLK100MHZ);
    chk("mrst_end_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
